// File: rtl/keypad_encoder_gen.sv
// Debounced priority keypad encoder with load strobe and a pgt_1hz count clock.
// Optional auto-repeat of the load strobe while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_encoder_gen #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CLK_DIV         = 100,
    parameter int LOAD_DELAY      = 7,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic                clk,
    input  logic                clearn,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic [CODE_W-1:0]   code,
    output logic                loadn,
    output logic                valid,
    output logic                pgt_1hz
);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DLY_W = $clog2(LOAD_DELAY + 1);
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(LOAD_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_s;
    logic [CODE_W-1:0]  cap_q, cap_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               valid_q, valid_d;
    logic               loadn_q, loadn_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic               pgt_q, pgt_d;
    logic [REP_W-1:0]   rep_q, rep_d, rep_inc_s;
    logic [CODE_W-1:0]  raw_s;
    logic               raw_vld_s;

    // Highest-index pressed key wins; raw_vld_s low means no key.
    always_comb begin
        raw_s     = '0;
        raw_vld_s = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            raw_s     = keypad[i] ? CODE_W'(i) : raw_s;
            raw_vld_s = raw_vld_s | keypad[i];
        end
    end

    assign cnt_inc_s = cnt_q + CNT_W'(1);
    assign rep_inc_s = rep_q + REP_W'(1);

    // Debounce FSM next-state, key capture and load strobe generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        code_d  = code_q;
        valid_d = valid_q;
        loadn_d = 1'b1;
        rep_d   = rep_q;
        if (enablen) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            rep_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (raw_vld_s) begin
                        state_d = ST_DEBOUNCE;
                        cap_d   = raw_s;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (raw_vld_s && (raw_s == cap_q)) begin
                        if (cnt_inc_s == DEB_LAST) begin
                            state_d = ST_PRESSED;
                            code_d  = cap_q;
                            valid_d = 1'b1;
                            loadn_d = 1'b0;
                            cnt_d   = '0;
                            rep_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc_s;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (raw_vld_s && (raw_s == code_q)) begin
                        if (AUTO_REPEAT && (rep_inc_s == REP_LAST)) begin
                            rep_d   = '0;
                            loadn_d = 1'b0;
                        end else begin
                            rep_d   = rep_inc_s;
                        end
                    end else begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (!raw_vld_s) begin
                        if (cnt_inc_s == DEB_LAST) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc_s;
                        end
                    end else begin
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Free-running divider plus the pgt_1hz source select and load-delay countdown.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        dly_d = dly_q;
        pgt_d = 1'b0;
        if (enablen) begin
            dly_d = '0;
            pgt_d = (div_q >= DIV_HALF);
        end else if (!loadn_d) begin
            // A fresh strobe restarts the delay and drops any pending pulse.
            dly_d = DLY_INIT;
            pgt_d = 1'b0;
        end else if (dly_q != '0) begin
            dly_d = dly_q - DLY_W'(1);
            pgt_d = (dly_q == DLY_ONE);
        end else begin
            dly_d = '0;
            pgt_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            loadn_q <= 1'b1;
            div_q   <= '0;
            dly_q   <= '0;
            pgt_q   <= 1'b0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            loadn_q <= loadn_d;
            div_q   <= div_d;
            dly_q   <= dly_d;
            pgt_q   <= pgt_d;
            rep_q   <= rep_d;
        end
    end

    assign code    = code_q;
    assign loadn   = loadn_q;
    assign valid   = valid_q;
    assign pgt_1hz = pgt_q;

endmodule

// File: tb/tb_keypad_encoder_gen.sv
// Randomized self-checking bench for keypad_encoder_gen against a cycle-level behavioural model.
module tb_keypad_encoder_gen;

    localparam int NK  = 10;
    localparam int CW  = 4;
    localparam int DEB = 8;
    localparam int DIV = 100;
    localparam int LD  = 7;
    localparam int REP = 50;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clearn = 1'b0;
    logic [NK-1:0] keypad = '0;
    logic          enablen = 1'b0;
    logic [CW-1:0] code;
    logic          loadn;
    logic          valid;
    logic          pgt_1hz;

    int vectors = 0;
    int miscompares = 0;

    // Model: n = edges since reset; run_* tracks a candidate key, quiet counts idle samples on release.
    int n, run_key, run_len, held, rel, quiet, code_m, last_load;
    int exp_loadn, exp_pgt, exp_valid;

    keypad_encoder_gen #(
        .NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(DEB),
        .CLK_DIV(DIV), .LOAD_DELAY(LD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .clearn(clearn), .keypad(keypad), .enablen(enablen),
        .code(code), .loadn(loadn), .valid(valid), .pgt_1hz(pgt_1hz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int top_key(input logic [NK-1:0] kp);
        int r = -1;
        for (int i = 0; i < NK; i++) if (kp[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        n = 0; run_key = -1; run_len = 0; held = 0; rel = 0; quiet = 0;
        code_m = 0; last_load = -1000;
        exp_loadn = 1; exp_pgt = 0; exp_valid = 0;
    endtask

    task automatic model_edge(input logic [NK-1:0] kp, input logic en);
        int r;
        r = top_key(kp);
        n++;
        exp_loadn = 1;
        if (en) begin
            run_len = 0; held = 0; rel = 0; quiet = 0; last_load = -1000;
            exp_pgt = (((n - 1) % DIV) >= DIV / 2) ? 1 : 0;
        end else begin
            if (held == 0) begin
                if (run_len == 0) begin
                    if (r >= 0) begin run_key = r; run_len = 1; end
                end else if (r == run_key) begin
                    run_len++;
                    if (run_len == DEB) begin
                        held = 1; rel = 0; code_m = r; run_len = 0;
                        exp_loadn = 0; last_load = n;
                    end
                end else begin
                    run_len = 0;
                end
            end else if (rel == 0) begin
                if (r != code_m) begin
                    rel = 1; quiet = 0;
                end else if (AUTO && (n - last_load == REP)) begin
                    exp_loadn = 0; last_load = n;
                end
            end else begin
                if (r < 0) begin
                    quiet++;
                    if (quiet == DEB) begin held = 0; rel = 0; end
                end else begin
                    quiet = 0;
                end
            end
            exp_pgt = (n == last_load + LD) ? 1 : 0;
        end
        exp_valid = held;
    endtask

    task automatic step(input logic [NK-1:0] kp, input logic en);
        keypad  = kp;
        enablen = en;
        @(posedge clk);
        model_edge(kp, en);
        #1;
        check_eq("code",    32'(code),    32'(code_m));
        check_eq("valid",   32'(valid),   32'(exp_valid));
        check_eq("loadn",   32'(loadn),   32'(exp_loadn));
        check_eq("pgt_1hz", 32'(pgt_1hz), 32'(exp_pgt));
    endtask

    task automatic hold(input logic [NK-1:0] kp, input logic en, input int cycles);
        for (int i = 0; i < cycles; i++) step(kp, en);
    endtask

    task automatic reset_pulse();
        clearn = 1'b0;
        #1;
        check_eq("rst_code",  32'(code),    32'd0);
        check_eq("rst_valid", 32'(valid),   32'd0);
        check_eq("rst_loadn", 32'(loadn),   32'd1);
        check_eq("rst_pgt",   32'(pgt_1hz), 32'd0);
        @(negedge clk);
        clearn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NK-1:0] kp;
        int dur;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Single key 5, then release.
        hold(10'b0000100000, 1'b0, 10);
        hold('0, 1'b0, 12);
        // Keys 2 and 7 together: 7 wins.
        hold(10'b0010000100, 1'b0, 10);
        hold('0, 1'b0, 10);
        // Short press of key 3 is never accepted.
        hold(10'b0000001000, 1'b0, 5);
        hold('0, 1'b0, 3);
        // Key 4 with a bounce during release.
        hold(10'b0000010000, 1'b0, 10);
        hold('0, 1'b0, 3);
        hold(10'b0000010000, 1'b0, 1);
        hold('0, 1'b0, 10);
        // Free-running timebase with keypad noise.
        for (int i = 0; i < 300; i++) step(NK'($urandom), 1'b1);
        // Reset at debounce count 6, then a full press afterwards.
        hold(10'b0001000000, 1'b0, 6);
        reset_pulse();
        hold(10'b0001000000, 1'b0, 10);
        hold('0, 1'b0, 10);
        // Long hold of key 9 (auto-repeat when enabled).
        hold(10'b1000000000, 1'b0, 200);
        hold('0, 1'b0, 10);

        // Random segments: idle, single keys, multi-key noise, enable toggles, resets.
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 4))
                0:       kp = '0;
                1, 2:    kp = NK'(1) << $urandom_range(0, NK - 1);
                3:       kp = NK'($urandom);
                default: kp = (NK'(1) << $urandom_range(0, NK - 1)) | (NK'(1) << $urandom_range(0, NK - 1));
            endcase
            dur = $urandom_range(1, 14);
            hold(kp, ($urandom_range(0, 9) == 0), dur);
            if ($urandom_range(0, 24) == 0) reset_pulse();
        end
        hold('0, 1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
